// File: rtl/riscv_definitions.sv
// riscv_definitions: shared LSU state encoding, funct3 access-size codes and alignment helper
package riscv_definitions;
  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE} lsu_state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // funct3[1:0] alone selects the size: 00 byte, 01 half, anything else a full word
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] != 2'b00 && f3[1:0] != 2'b01 && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data-memory request/response bus between the LSU and memory
interface lsu_ctrl_if;
  logic req, we, gnt, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication and load lane extraction with extension
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext
);
  logic sz_b, sz_h;
  logic [31:0] sh;
  assign sz_b = funct3[1:0] == 2'b00;
  assign sz_h = funct3[1:0] == 2'b01;
  assign sh   = sz_b ? rdata >> {off, 3'b000} : rdata >> {off[1], 4'b0000};
  assign be   = sz_b ? 4'b0001 << off : sz_h ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  assign wrep = sz_b ? {4{wdata[7:0]}} : sz_h ? {2{wdata[15:0]}} : wdata;
  assign rext = sz_b ? {{24{~funct3[2] & sh[7]}}, sh[7:0]}
              : sz_h ? {{16{~funct3[2] & sh[15]}}, sh[15:0]} : rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit bus controller with timeout abort.
// Define LSU_MISALIGN_TRAP_EN to abort misaligned half/word accesses without a bus request.
module lsu_ctrl
  import riscv_definitions::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_bus_err,
  output logic        o_misaligned,
  lsu_ctrl_if.master  dmem
);
  lsu_state_e state, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d, wrep, rext;
  logic [2:0] f3_q;
  logic [7:0] cnt_q;
  logic [3:0] be;
  logic we_q, err_q, err_d, mis_q, mis, accept, hit, busy;
  assign accept = i_rst_n && state == LSU_IDLE && (i_mem_read || i_mem_write);
  assign busy   = state == LSU_REQ || state == LSU_WAIT;
  assign hit    = busy && (cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES);
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = misaligned(i_funct3, i_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  lsu_align u_align (
    .funct3(f3_q), .off(addr_q[1:0]), .wdata(wdata_q), .rdata(dmem.rdata),
    .be(be), .wrep(wrep), .rext(rext)
  );
  // rvalid has priority over a timeout landing in the same WAIT cycle
  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    case (state)
      LSU_IDLE: state_d = accept ? (mis ? LSU_DONE : LSU_REQ) : LSU_IDLE;
      LSU_REQ:  state_d = hit ? LSU_DONE : dmem.gnt ? LSU_WAIT : LSU_REQ;
      LSU_WAIT: state_d = (dmem.rvalid || hit) ? LSU_DONE : LSU_WAIT;
      default:  state_d = LSU_IDLE;
    endcase
    err_d   = hit && !(state == LSU_WAIT && dmem.rvalid);
    rdata_d = (state == LSU_WAIT && dmem.rvalid && !we_q) ? rext : 32'd0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state   <= LSU_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_d;
      cnt_q <= accept ? 8'd0 : busy ? cnt_q + 8'd1 : cnt_q;
      if (accept) begin
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        f3_q    <= i_funct3;
        we_q    <= !i_mem_read;
      end
      if (state_d == LSU_DONE && state != LSU_DONE) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
        mis_q   <= accept;
      end
    end
  assign o_stall      = accept || busy;
  assign o_done       = state == LSU_DONE;
  assign o_rdata      = o_done ? rdata_q : 32'd0;
  assign o_bus_err    = o_done && err_q;
  assign o_misaligned = o_done && mis_q;
  assign dmem.req     = state == LSU_REQ;
  assign dmem.we      = dmem.req && we_q;
  assign dmem.addr    = dmem.req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem.be      = dmem.req ? be : 4'd0;
  assign dmem.wdata   = dmem.req ? wrep : 32'd0;
endmodule
